lsearch_ctrl: RTL
=================

LSEARCH_CTRL -- requirements
Module: lsearch_ctrl

Interface
REQ-001 The block SHALL have parameter A, default 8, giving the RAM address width.
REQ-002 The block SHALL have parameter D, default 8, giving the RAM data width.
REQ-003 The block SHALL have parameter R, default 256 (2^A), giving the RAM depth.
REQ-004 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-006 Port start  input  1  SHALL request a search; sampled only in IDLE.
REQ-007 Port key  input  D  SHALL be the search value, captured with start.
REQ-008 Port len  input  A+1  SHALL be the number of words to scan (0..R), captured with start.
REQ-009 Ports ld_we  input  1, ld_addr  input  A and ld_data  input  D SHALL form the load path, accepted only when busy=0.
REQ-010 Port busy  output  1  SHALL be high in SCAN.
REQ-011 Port done  output  1  SHALL be a one-cycle completion pulse.
REQ-012 Port found  output  1  SHALL be the match flag, valid with done and held until the next start.
REQ-013 Port index  output  A  SHALL be the lowest matching address, valid when found=1.
REQ-014 Ports mem_ce  output  1, mem_we  output  1, mem_addr  output  A and mem_data  output  D SHALL drive the RAM.
REQ-015 Port mem_q  input  D  SHALL be the RAM read data, valid the cycle after an address is sampled with mem_ce=1.

Function
REQ-016 The FSM SHALL have states IDLE, SCAN and DONE.
REQ-017 IDLE->SCAN SHALL occur on start=1; key and len are latched and the issue pointer ip and the compare pointer cp are cleared.
REQ-018 DONE->IDLE SHALL occur unconditionally after one cycle; done=1 only in DONE.
REQ-019 In IDLE/DONE: mem_ce=ld_we, mem_we=ld_we, mem_addr=ld_addr, mem_data=ld_data.
REQ-020 In SCAN: mem_we=0; mem_ce=1 with mem_addr=ip while ip<len and no match is seen; ip increments per issued read.
REQ-021 The pipeline SHALL be one stage: a compare-valid flag set the cycle after each issued read compares mem_q==key for address cp, then cp increments.
REQ-022 A first match at cp=k SHALL register found=1 and index=k and go to DONE; done is visible at edge E0+k+2, where E0 is the start edge.
REQ-023 With no match, the compare of address len-1 SHALL go to DONE with found=0; done is visible at edge E0+len+1.
REQ-024 len=0 SHALL go straight to DONE at edge E0+1 with found=0 and no RAM read issued.
REQ-025 When several addresses match, the lowest SHALL win; no read beyond the match address k+1 is issued.
REQ-026 start in SCAN or DONE SHALL be ignored and not queued.
REQ-027 ld_we in SCAN SHALL be ignored and never reach the RAM.
REQ-028 start and ld_we together in IDLE: the load SHALL be forwarded that cycle and the search starts next cycle.
REQ-029 All compares SHALL be D-bit equality; pointers SHALL be A+1 bits so len=R does not wrap.

Reset
REQ-030 rst_n=0 SHALL force IDLE, busy=0, done=0, found=0 and index=0; mem_ce and mem_we follow ld_we per REQ-019.
REQ-031 Reset during SCAN SHALL abort with no done pulse; the RAM contents are untouched.

Structure
REQ-032 A package lsearch_pkg SHALL hold the state enum and the default A/D/R constants.
REQ-033 No sub-module SHALL be used; the RAM is instantiated beside this block by the integrating level.

Verification
REQ-034 Load mem[i]=i for i=0..255; key=0x05, len=256 -> done at E0+7, found=1, index=5.
REQ-035 Same contents; key=0xFF, len=255 -> done at E0+256, found=0.
REQ-036 mem[3]=mem[9]=0xAA; key=0xAA, len=16 -> index=3; mem_addr never exceeds 4.
REQ-037 len=0 -> done at E0+1, found=0, mem_ce never high; start pulsed during SCAN -> ignored, exactly one done.
REQ-038 ld_we=1 mid-SCAN to addr 2 -> mem_we stays 0 and mem[2] is unchanged; rst_n=0 mid-SCAN -> busy=0 next cycle, no done.

Source files
------------

// File: rtl/lsearch_pkg.sv
// Shared types and default geometry for the linear-search controller.
package lsearch_pkg;

    // Default RAM geometry: 256 words of 8 bits.
    localparam int unsigned ADefault = 8;
    localparam int unsigned DDefault = 8;
    localparam int unsigned RDefault = 256;

    // Controller states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage : lsearch_pkg

// File: rtl/lsearch_ctrl.sv
// Linear-search controller: scans RAM words 0..len-1 for a key through a single-port RAM
// with one cycle of read latency, reporting the lowest matching address.
// When idle, the RAM port is handed to the external load path.
module lsearch_ctrl
    import lsearch_pkg::*;
#(
    parameter int unsigned A = ADefault,
    parameter int unsigned D = DDefault,
    parameter int unsigned R = RDefault
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [D-1:0] key,
    input  logic [A:0]   len,
    input  logic         ld_we,
    input  logic [A-1:0] ld_addr,
    input  logic [D-1:0] ld_data,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [A-1:0] index,
    output logic         mem_ce,
    output logic         mem_we,
    output logic [A-1:0] mem_addr,
    output logic [D-1:0] mem_data,
    input  logic [D-1:0] mem_q
);

    // Largest legal length; a larger request is clipped so the scan never leaves the RAM.
    localparam logic [A:0] LenMax = (A + 1)'(R);

    state_e       state_q, state_d;
    logic [D-1:0] key_q, key_d;
    logic [A:0]   len_q, len_d;
    logic [A:0]   ip_q, ip_d;      // next address to issue
    logic [A:0]   cp_q, cp_d;      // address whose data is on mem_q when cmp_valid_q
    logic         cmp_valid_q, cmp_valid_d;
    logic         found_q, found_d;
    logic [A-1:0] index_q, index_d;

    logic         in_scan;
    logic         hit;
    logic         last_cmp;
    logic         issue;
    logic [A:0]   len_clip;
    logic [A:0]   cp_inc;

    assign in_scan  = (state_q == StScan);
    assign cp_inc   = cp_q + 1'b1;
    assign len_clip = (len > LenMax) ? LenMax : len;

    // Compare-stage results; only meaningful while scanning.
    assign hit      = in_scan && cmp_valid_q && (mem_q == key_q);
    assign last_cmp = in_scan && cmp_valid_q && (cp_inc == len_q);

    // A read is issued while addresses remain and the word just returned did not match,
    // so nothing past the matching address is ever fetched.
    assign issue    = in_scan && (ip_q < len_q) && !hit;

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            key_q       <= '0;
            len_q       <= '0;
            ip_q        <= '0;
            cp_q        <= '0;
            cmp_valid_q <= 1'b0;
            found_q     <= 1'b0;
            index_q     <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            len_q       <= len_d;
            ip_q        <= ip_d;
            cp_q        <= cp_d;
            cmp_valid_q <= cmp_valid_d;
            found_q     <= found_d;
            index_q     <= index_d;
        end
    end

    // Next-state logic for the controller FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StScan;
                end
            end
            StScan: begin
                // Empty scan, first match, or final compare all finish the search.
                if (hit || last_cmp || (len_q == '0)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Datapath next-state: capture on start, advance pointers and record a match while scanning.
    always_comb begin
        key_d       = key_q;
        len_d       = len_q;
        ip_d        = ip_q;
        cp_d        = cp_q;
        cmp_valid_d = 1'b0;
        found_d     = found_q;
        index_d     = index_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    key_d   = key;
                    len_d   = len_clip;
                    ip_d    = '0;
                    cp_d    = '0;
                    found_d = 1'b0;
                    index_d = '0;
                end
            end
            StScan: begin
                cmp_valid_d = issue;
                if (issue) begin
                    ip_d = ip_q + 1'b1;
                end
                if (cmp_valid_q) begin
                    cp_d = cp_inc;
                end
                if (hit) begin
                    found_d = 1'b1;
                    index_d = cp_q[A-1:0];
                end
            end
            default: begin
            end
        endcase
    end

    // Outputs: status flags and RAM port ownership (load path unless scanning).
    always_comb begin
        busy     = in_scan;
        done     = (state_q == StDone);
        mem_ce   = ld_we;
        mem_we   = ld_we;
        mem_addr = ld_addr;
        mem_data = ld_data;
        if (in_scan) begin
            mem_ce   = issue;
            mem_we   = 1'b0;
            mem_addr = ip_q[A-1:0];
            mem_data = '0;
        end
    end

    assign found = found_q;
    assign index = index_q;

    // The load path must never write the RAM while a scan owns it.
    assert property (@(posedge clk) disable iff (!rst_n) busy |-> !mem_we);

    // Completion is a single-cycle pulse.
    assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);

endmodule : lsearch_ctrl
